// File: rtl/seat_hold_ctrl.sv
// Seat reservation table: RESERVE/RELEASE/EXTEND commands, round-robin expiry
// scan against the library clock, and a once-per-day sequential table clear.
module seat_hold_ctrl #(
  parameter int unsigned NUM_SEATS    = 32,
  parameter int unsigned SEAT_W       = 5,
  parameter int unsigned USER_W       = 8,
  parameter int unsigned MAX_HOLD_MIN = 240
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       time_in,
  input  logic              day_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [SEAT_W-1:0] req_seat,
  input  logic [USER_W-1:0] req_user,
  input  logic [7:0]        req_dur,
  output logic              rsp_valid,
  output logic              rsp_ok,
  output logic [SEAT_W-1:0] rsp_seat,
  output logic              exp_valid,
  output logic [SEAT_W-1:0] exp_seat,
  output logic [SEAT_W:0]   free_cnt
);

  typedef enum logic {RUN, CLEAR} state_t;

  localparam logic [SEAT_W:0]   NUM_SEATS_W = SEAT_W'(NUM_SEATS) | ((SEAT_W+1)'(NUM_SEATS) & {1'b1, {SEAT_W{1'b0}}});
  localparam logic [SEAT_W-1:0] LAST_SEAT   = SEAT_W'(NUM_SEATS - 1);
  localparam logic [11:0]       DAY_END     = 12'd1439;
  localparam logic [11:0]       HOLD        = 12'(MAX_HOLD_MIN);

  state_t              state_q, state_d;
  logic                day_rst_q;
  logic [NUM_SEATS-1:0] occ;
  logic [USER_W-1:0]   owner [NUM_SEATS];
  logic [10:0]         end_t [NUM_SEATS];
  logic [SEAT_W-1:0]   scan_ptr, clr_ptr;

  logic [4:0]  hr_c;
  logic [5:0]  mn_c;
  logic [11:0] now;

  assign hr_c = (time_in[10:6] > 5'd23) ? 5'd23 : time_in[10:6];
  assign mn_c = (time_in[5:0] > 6'd59) ? 6'd59 : time_in[5:0];
  assign now  = 12'(hr_c) * 12'd60 + 12'(mn_c);

  assign req_ready = (state_q == RUN) & ~rst;

  logic        accept, seat_ok, cur_occ, owner_ok;
  logic        cmd_ok, cmd_set, cmd_ext, cmd_free;
  logic [11:0] dur12, dur_cap, res_sum, res_end, ext_sum, ext_lim, ext_min, ext_end, new_end;
  logic        scan_hit, scan_stall, scan_free, clr_free, clr_exp, day_rise;

  always_comb begin
    accept   = req_valid & req_ready;
    seat_ok  = ({1'b0, req_seat} < NUM_SEATS_W);
    cur_occ  = seat_ok & occ[req_seat];
    owner_ok = cur_occ & (owner[req_seat] == req_user);

    dur12   = 12'(req_dur);
    dur_cap = (dur12 > HOLD) ? HOLD : dur12;
    res_sum = now + dur_cap;
    res_end = (res_sum > DAY_END) ? DAY_END : res_sum;
    ext_sum = {1'b0, end_t[req_seat]} + dur12;
    ext_lim = now + HOLD;
    ext_min = (ext_sum < ext_lim) ? ext_sum : ext_lim;
    ext_end = (ext_min > DAY_END) ? DAY_END : ext_min;

    cmd_ok   = 1'b0;
    cmd_set  = 1'b0;
    cmd_ext  = 1'b0;
    cmd_free = 1'b0;
    new_end  = res_end;
    if (accept && seat_ok) begin
      case (req_op)
        2'd0: if (!cur_occ && req_dur != 8'd0) begin
          cmd_ok  = 1'b1;
          cmd_set = 1'b1;
        end
        2'd1: if (owner_ok) begin
          cmd_ok   = 1'b1;
          cmd_free = 1'b1;
        end
        2'd2: if (owner_ok) begin
          cmd_ok  = 1'b1;
          cmd_ext = (req_dur != 8'd0);
          new_end = ext_end;
        end
        default: ;
      endcase
    end

    // A command on the scanned seat wins; a successful release elsewhere holds
    // the scan one cycle so free_cnt never moves by more than one.
    scan_hit   = (state_q == RUN) && occ[scan_ptr] && (now >= {1'b0, end_t[scan_ptr]})
                 && !(accept && req_seat == scan_ptr);
    scan_stall = scan_hit & cmd_free;
    scan_free  = scan_hit & ~scan_stall;

    clr_free = (state_q == CLEAR);
    clr_exp  = clr_free & occ[clr_ptr];
    day_rise = day_rst & ~day_rst_q;

    state_d = state_q;
    case (state_q)
      RUN:     if (day_rise) state_d = CLEAR;
      CLEAR:   if (clr_ptr == LAST_SEAT) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  logic inc, dec;
  assign inc = cmd_free | scan_free | clr_exp;
  assign dec = cmd_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      day_rst_q <= 1'b0;
      occ       <= '0;
      for (int unsigned i = 0; i < NUM_SEATS; i++) begin
        owner[i] <= '0;
        end_t[i] <= '0;
      end
      scan_ptr  <= '0;
      clr_ptr   <= '0;
      rsp_valid <= 1'b0;
      rsp_ok    <= 1'b0;
      rsp_seat  <= '0;
      exp_valid <= 1'b0;
      exp_seat  <= '0;
      free_cnt  <= NUM_SEATS_W;
    end else begin
      state_q   <= state_d;
      day_rst_q <= day_rst;

      rsp_valid <= accept;
      rsp_ok    <= cmd_ok;
      if (accept) rsp_seat <= req_seat;

      exp_valid <= scan_free | clr_exp;
      if (scan_free)    exp_seat <= scan_ptr;
      else if (clr_exp) exp_seat <= clr_ptr;

      if (cmd_set) begin
        occ[req_seat]   <= 1'b1;
        owner[req_seat] <= req_user;
        end_t[req_seat] <= new_end[10:0];
      end
      if (cmd_ext) end_t[req_seat] <= new_end[10:0];
      if (cmd_free) begin
        occ[req_seat]   <= 1'b0;
        owner[req_seat] <= '0;
        end_t[req_seat] <= '0;
      end
      if (scan_free) begin
        occ[scan_ptr]   <= 1'b0;
        owner[scan_ptr] <= '0;
        end_t[scan_ptr] <= '0;
      end
      if (clr_free) begin
        occ[clr_ptr]   <= 1'b0;
        owner[clr_ptr] <= '0;
        end_t[clr_ptr] <= '0;
      end

      if (state_q == RUN && !scan_stall)
        scan_ptr <= (scan_ptr == LAST_SEAT) ? '0 : scan_ptr + 1'b1;
      if (state_q == CLEAR)
        clr_ptr <= (clr_ptr == LAST_SEAT) ? '0 : clr_ptr + 1'b1;
      else
        clr_ptr <= '0;

      if (inc && !dec)      free_cnt <= free_cnt + 1'b1;
      else if (dec && !inc) free_cnt <= free_cnt - 1'b1;
    end
  end

endmodule
